// File: rtl/gpio_csr_bank.sv
// ============================================================================
// Module      : gpio_csr_bank
// Description : GPIO CSR bank with switch input, LED output, pending/enable
//               interrupts and a one-access-per-two-cycles strobe/ack bus.
//               Optional per-bit switch debounce when GPIO_DEBOUNCE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_csr_bank #(
  parameter int data_width      = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width:0]   sw_reg,
  output logic [data_width:0]   led_reg,
  input  logic                  bus_stb,
  input  logic                  bus_we,
  input  logic [1:0]            bus_adr,
  input  logic [31:0]           bus_dat_w,
  output logic [31:0]           bus_dat_r,
  output logic                  bus_ack,
  output logic                  irq
);

  localparam int         c_DW        = data_width + 1;
  localparam logic [1:0] c_ADR_SW    = 2'd0;
  localparam logic [1:0] c_ADR_LED   = 2'd1;
  localparam logic [1:0] c_ADR_PEND  = 2'd2;
  localparam logic [1:0] c_ADR_EN    = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t              r_state;
  logic [data_width:0] r_sync1;
  logic [data_width:0] r_sync2;
  logic [data_width:0] r_sw_prev;
  logic [data_width:0] r_pend;
  logic [data_width:0] r_en;
  logic [data_width:0] w_sw_cur;
  logic [data_width:0] w_edge;
  logic [data_width:0] w_wdat;
  logic [data_width:0] w_rd_val;
  logic                w_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_reg;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Debounced bit only follows sw_s after an unbroken run of differing samples.
  for (genvar i = 0; i < c_DW; i++) begin : g_db
    logic [c_CW-1:0] r_cnt;
    logic            r_db;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_sync2[i] != r_db) begin
        if (r_cnt == c_CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db  <= r_sync2[i];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_sw_cur[i] = r_db;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES == 0);
  assign w_sw_cur     = r_sync2;
`endif

  logic w_unused_dat;
  assign w_unused_dat = &{1'b0, bus_dat_w[31:c_DW]};

  assign w_edge = w_sw_cur & ~r_sw_prev;
  assign w_wdat = bus_dat_w[data_width:0];
  assign w_acc  = (r_state == IDLE) && bus_stb;

  always_comb begin
    w_rd_val = '0;
    case (bus_adr)
      c_ADR_SW:   w_rd_val = w_sw_cur;
      c_ADR_LED:  w_rd_val = led_reg;
      c_ADR_PEND: w_rd_val = r_pend;
      c_ADR_EN:   w_rd_val = r_en;
      default:    w_rd_val = '0;
    endcase
  end

  // Bus FSM, register writes and interrupt state share one clocked process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      bus_ack   <= 1'b0;
      bus_dat_r <= '0;
      led_reg   <= '0;
      r_en      <= '0;
      r_pend    <= '0;
      r_sw_prev <= '0;
      irq       <= 1'b0;
    end else begin
      r_sw_prev <= w_sw_cur;
      irq       <= |(r_pend & r_en);

      if (w_acc && bus_we && (bus_adr == c_ADR_PEND)) begin
        r_pend <= (r_pend & ~w_wdat) | w_edge;
      end else begin
        r_pend <= r_pend | w_edge;
      end

      case (r_state)
        IDLE: begin
          if (bus_stb) begin
            r_state   <= ACK;
            bus_ack   <= 1'b1;
            bus_dat_r <= {{(32-c_DW){1'b0}}, w_rd_val};
            if (bus_we) begin
              if (bus_adr == c_ADR_LED) led_reg <= w_wdat;
              if (bus_adr == c_ADR_EN)  r_en    <= w_wdat;
            end
          end
        end
        ACK: begin
          r_state   <= IDLE;
          bus_ack   <= 1'b0;
          bus_dat_r <= '0;
        end
        default: begin
          r_state   <= IDLE;
          bus_ack   <= 1'b0;
          bus_dat_r <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_csr_bank.sv
// ============================================================================
// Module      : tb_gpio_csr_bank
// Description : Self-checking bench for gpio_csr_bank (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_csr_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw_reg = 4'h0;
  logic [3:0]  led_reg;
  logic        bus_stb = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_adr = 2'd0;
  logic [31:0] bus_dat_w = 32'h0;
  logic [31:0] bus_dat_r;
  logic        bus_ack;
  logic        irq;

  int checks = 0;
  int failures = 0;

  gpio_csr_bank #(.data_width(3), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw_reg(sw_reg), .led_reg(led_reg),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_dat_w(bus_dat_w), .bus_dat_r(bus_dat_r), .bus_ack(bus_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  // One bus access; returns the read data captured with the ack pulse.
  task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] d,
                     output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_stb = 1'b1; bus_we = we; bus_adr = adr; bus_dat_w = d;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (bus_ack) begin
        got = 1;
        rd  = bus_dat_r;
      end
    end
    bus_stb = 1'b0; bus_we = 1'b0;
    chk("ack_seen", {31'h0, got}, 32'h1);
    @(posedge clk); #1;
    chk("ack_single", {31'h0, bus_ack}, 32'h0);
    chk("dat_r_idle", bus_dat_r, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [31:0] rd;

  initial begin
    vecs[0] = '{1'b1, 2'd1, 32'h0000_0005, 32'h0, 4'h5};
    vecs[1] = '{1'b0, 2'd1, 32'h0,         32'h0000_0005, 4'h5};
    vecs[2] = '{1'b1, 2'd1, 32'hFFFF_FFFA, 32'h0, 4'hA};
    vecs[3] = '{1'b0, 2'd1, 32'h0,         32'h0000_000A, 4'hA};
    vecs[4] = '{1'b1, 2'd0, 32'h0000_000F, 32'h0, 4'hA};
    vecs[5] = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, 4'hA};
    vecs[6] = '{1'b1, 2'd3, 32'h0000_0003, 32'h0, 4'hA};
    vecs[7] = '{1'b0, 2'd3, 32'h0,         32'h0000_0003, 4'hA};
    vecs[8] = '{1'b1, 2'd3, 32'h0000_00F0, 32'h0, 4'hA};
    vecs[9] = '{1'b0, 2'd3, 32'h0,         32'h0000_0000, 4'hA};

    do_reset();
    chk("rst_led", {28'h0, led_reg}, 32'h0);
    chk("rst_ack", {31'h0, bus_ack}, 32'h0);
    chk("rst_dat_r", bus_dat_r, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("rst_pend", rd, 32'h0);

    for (int i = 0; i < 10; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd);
      if (!vecs[i].we) chk("vec_rd", rd, vecs[i].exp_rd);
      chk("vec_led", {28'h0, led_reg}, {28'h0, vecs[i].exp_led});
    end

`ifndef GPIO_DEBOUNCE_EN
    // Rising edge on bit 1 with all enables on: pend after 3 edges, irq one later.
    bus(1'b1, 2'd3, 32'hF, rd);
    @(negedge clk); sw_reg = 4'h2;
    cycles(3);
    chk("irq_before", {31'h0, irq}, 32'h0);
    cycles(1);
    chk("irq_after_edge", {31'h0, irq}, 32'h1);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("pend_bit1", rd, 32'h2);
    bus(1'b1, 2'd2, 32'h2, rd);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("pend_cleared", rd, 32'h0);

    // Falling edge must not set anything.
    @(negedge clk); sw_reg = 4'h0;
    cycles(6);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("fall_ignored", rd, 32'h0);

    // Set pending, then W1C exactly on the edge of a new rising edge: set wins.
    @(negedge clk); sw_reg = 4'h2;
    cycles(6);
    @(negedge clk); sw_reg = 4'h0;
    cycles(6);
    @(negedge clk); sw_reg = 4'h2;
    @(posedge clk); @(posedge clk); #1;
    bus(1'b1, 2'd2, 32'h2, rd);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("set_beats_clear", rd, 32'h2);
    chk("irq_set_beats", {31'h0, irq}, 32'h1);

    // Disabled pending is retained and raises irq once enabled.
    bus(1'b1, 2'd3, 32'h0, rd);
    bus(1'b1, 2'd2, 32'hF, rd);
    @(negedge clk); sw_reg = 4'hA;
    cycles(6);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("pend_bit3", rd, 32'h8);
    chk("irq_disabled", {31'h0, irq}, 32'h0);
    bus(1'b1, 2'd3, 32'h8, rd);
    chk("irq_enabled", {31'h0, irq}, 32'h1);
    bus(1'b0, 2'd0, 32'h0, rd);
    chk("sw_in", rd, 32'hA);
`else
    // Short glitch filtered; long high accepted.
    bus(1'b1, 2'd2, 32'hF, rd);
    @(negedge clk); sw_reg = 4'h1;
    cycles(5);
    @(negedge clk); sw_reg = 4'h0;
    cycles(30);
    bus(1'b0, 2'd0, 32'h0, rd);
    chk("db_glitch_sw", rd, 32'h0);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("db_glitch_pend", rd, 32'h0);
    @(negedge clk); sw_reg = 4'h1;
    cycles(22);
    bus(1'b0, 2'd0, 32'h0, rd);
    chk("db_high_sw", rd, 32'h1);
    bus(1'b0, 2'd2, 32'h0, rd);
    chk("db_high_pend", rd, 32'h1);
    bus(1'b1, 2'd3, 32'h1, rd);
    chk("db_irq", {31'h0, irq}, 32'h1);
`endif

    // Reset in the middle of an ack: outputs clear immediately.
    bus(1'b1, 2'd1, 32'hA, rd);
    chk("led_pre_rst", {28'h0, led_reg}, 32'hA);
    @(negedge clk);
    bus_stb = 1'b1; bus_we = 1'b0; bus_adr = 2'd1;
    begin
      bit got;
      got = 0;
      for (int n = 0; n < 8 && !got; n++) begin
        @(posedge clk); #1;
        if (bus_ack) got = 1;
      end
      chk("ack_before_rst", {31'h0, got}, 32'h1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'h0, bus_ack}, 32'h0);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    chk("rst_mid_led", {28'h0, led_reg}, 32'h0);
    chk("rst_mid_dat", bus_dat_r, 32'h0);
    cycles(2);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("new_access_ack", {31'h0, bus_ack}, 32'h1);
    bus_stb = 1'b0;
    cycles(1);
    chk("new_access_done", {31'h0, bus_ack}, 32'h0);
    cycles(25);
    bus(1'b0, 2'd0, 32'h0, rd);
    begin
      logic [31:0] sw_before;
      sw_before = rd;
      bus(1'b1, 2'd0, 32'hF, rd);
      bus(1'b0, 2'd0, 32'h0, rd);
      chk("sw_in_ro", rd, sw_before);
`ifndef GPIO_DEBOUNCE_EN
      chk("sw_in_val", rd, 32'hA);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/gpio_csr_bank.md
GPIO_CSR_BANK -- requirements
Module: gpio_csr_bank

Interface
REQ-001 SHALL have parameter data_width, default 3, MSB index of switch/LED vectors (vector width data_width+1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-sample count used only when debounce is compiled in.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sw_reg  in  data_width+1  switch sample from the GPIO pad block
- led_reg  out  data_width+1  LED value to the GPIO pad block
- bus_stb  in  1  request strobe, held until ack
- bus_we  in  1  1 = write, 0 = read
- bus_adr  in  2  register index
- bus_dat_w  in  32  write data
- bus_dat_r  out  32  read data, valid with bus_ack
- bus_ack  out  1  one-cycle completion pulse
- irq  out  1  level interrupt to CPU

Function
REQ-004 SHALL pass sw_reg through a 2-flop synchronizer; synchronized value = sw_s.
REQ-005 SHALL implement registers, zero-extended to 32 bits on read:
- 0 SW_IN  RO  sw_s (or debounced value, REQ-018)
- 1 LED_OUT  RW  drives led_reg directly
- 2 IRQ_PEND  R/W1C  per-bit rising-edge flags
- 3 IRQ_EN  RW  per-bit enables
REQ-006 SHALL use a 2-state FSM: IDLE -> ACK when bus_stb=1; ACK -> IDLE unconditionally.
REQ-007 SHALL assert bus_ack exactly one cycle, the cycle after bus_stb is sampled in IDLE; a strobe held across ACK starts a new access only after returning to IDLE (max one access per 2 cycles).
REQ-008 SHALL perform the register write and capture bus_dat_r on the IDLE->ACK transition edge; bus_dat_r SHALL be 0 outside ACK.
REQ-009 SHALL ignore writes to SW_IN; bus_ack still pulses.
REQ-010 SHALL use only bus_dat_w[data_width:0] on writes; upper bits ignored, read back as 0.
REQ-011 SHALL set IRQ_PEND[i] when the (debounced) switch bit i goes 0->1 between consecutive cycles; falling edges ignored.
REQ-012 SHALL clear IRQ_PEND[i] on write to address 2 with bus_dat_w[i]=1; writing 0 leaves it unchanged.
REQ-013 SHALL give set priority over clear when an edge and a W1C hit the same bit in the same cycle.
REQ-014 SHALL drive irq = OR of (IRQ_PEND & IRQ_EN), registered, one cycle after the pending/enable update.
REQ-015 SHALL retain pending bits while disabled; enabling later asserts irq.

Reset
REQ-016 SHALL on rst_n=0, asynchronously: led_reg=0, IRQ_PEND=0, IRQ_EN=0, synchronizer/edge history=0, irq=0, bus_ack=0, bus_dat_r=0, FSM=IDLE.
REQ-017 SHALL abort an access in progress on reset; no ack is issued for it after release, and a strobe still high after release is serviced as a new access.

Configuration
REQ-018 With macro GPIO_DEBOUNCE_EN defined, SHALL add per-bit counters: a bit's debounced value updates only after sw_s differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the current value resets that counter; counters and debounced value reset to 0.
REQ-019 Without GPIO_DEBOUNCE_EN, SHALL use sw_s directly with no counters; SW_IN and edge detection see sw_s.

Verification
REQ-020 Write 0x5 to adr 1, then read adr 1 -> led_reg=0x5 after the write-ack cycle; read returns 0x00000005 with a single ack pulse.
REQ-021 IRQ_EN=0xF, sw_reg 0x0->0x2 (no debounce) -> IRQ_PEND=0x2 after 3 cycles, irq=1 one cycle later; write 0x2 to adr 2 -> irq=0.
REQ-022 Pending bit 1 set, W1C of 0x2 in the same cycle as a new rising edge on bit 1 -> IRQ_PEND stays 0x2.
REQ-023 IRQ_EN=0, edge on bit 3 -> IRQ_PEND=0x8, irq=0; write 0x8 to adr 3 -> irq=1.
REQ-024 GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 5-cycle glitch on bit 0 -> SW_IN=0, no pending; 20-cycle high -> SW_IN=0x1, IRQ_PEND=0x1.
REQ-025 rst_n low during ACK with led_reg=0xA -> bus_ack, irq, led_reg all 0 immediately; write 0xF to adr 0 after release -> ack, SW_IN unchanged.
